// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch slice: word width, fetch FSM states
// and the {addr,data} entry carried through the instruction buffer.
package riscv_pkg;
  localparam int              XLEN         = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } fetch_ent_t;
endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory port: valid/ready request plus fixed-latency response pulse.
interface if_fetch_if;
  import riscv_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_buf.sv
// Small sync FIFO of fetched {addr,data} entries; flush beats push.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_ent_t wdata,
  output fetch_ent_t rdata,
  output logic [AW:0] count,
  output logic       full,
  output logic       empty
);
  fetch_ent_t  mem [DEPTH];
  logic [AW:0] wptr, rptr;

  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr[AW-1:0]];

  // Caller guarantees push only when there is room (or a pop frees one).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC, single-outstanding imem requests and a buffer toward decode.
// Redirects flush the buffer; a request already on the bus is drained and its data dropped.
module if_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jmp,
  input  logic [XLEN-1:0] new_inst_addr,
  if_fetch_if.master      imem,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_addr
);
  localparam int AW = $clog2(BUF_DEPTH);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, hold_addr, out_addr;
  logic            outstanding, req_hold;
  logic            issue_now, push, pop, accept, rsp_take, need_drain;
  logic            full, empty;
  logic [AW:0]     count;
  logic [AW+1:0]   occ;
  fetch_ent_t      head, wr_ent;

  assign accept     = imem.req_valid && imem.req_ready;
  assign rsp_take   = imem.rsp_valid && outstanding;
  // A redirect must drain if a request stays on the bus past this edge.
  assign need_drain = (outstanding && !imem.rsp_valid) || req_hold;
  assign occ        = {1'b0, count} + (AW+2)'(outstanding);
  assign pop        = inst_valid && inst_ready;
  assign wr_ent     = '{addr: out_addr, data: imem.rsp_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (jmp && need_drain) state_nxt = DRAIN;
      DRAIN:   if (jmp)           state_nxt = need_drain ? DRAIN : RUN;
               else if (rsp_take) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // A retiring response frees the single outstanding slot in the same cycle.
  always_comb begin
    issue_now      = 1'b0;
    push           = 1'b0;
    imem.req_valid = 1'b0;
    imem.req_addr  = '0;
    if (state == RUN && !req_hold && !jmp && (!outstanding || rsp_take) &&
        occ < (AW+2)'(BUF_DEPTH))
      issue_now = 1'b1;
    if (rsp_take && state != DRAIN && !jmp && (!full || pop)) push = 1'b1;
    if (req_hold) begin
      imem.req_valid = 1'b1;
      imem.req_addr  = hold_addr;
    end else if (issue_now) begin
      imem.req_valid = 1'b1;
      imem.req_addr  = pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= 1'b0;
      req_hold    <= 1'b0;
      hold_addr   <= '0;
      out_addr    <= '0;
    end else begin
      req_hold <= imem.req_valid && !imem.req_ready;
      if (issue_now) hold_addr <= pc;
      if (accept) begin
        outstanding <= 1'b1;
        out_addr    <= imem.req_addr;
      end else if (imem.rsp_valid) begin
        outstanding <= 1'b0;
      end
      // A stale request accepted during DRAIN must not advance the new stream.
      if (jmp)                         pc <= new_inst_addr & ~XLEN'(3);
      else if (accept && state == RUN) pc <= pc + XLEN'(4);
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (jmp),
    .wdata (wr_ent),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign inst_valid = !empty;
  assign inst       = head.data;
  assign inst_addr  = head.addr;
endmodule
